uart_tx: RTL and testbench

UART serial transmitter. It is the transmit counterpart of the team's 16x-oversampled UART receiver and shares its baud-rate tick generator.
- Accepts one parallel byte per start request.
- Emits the frame LSB-first on a registered tx line: start bit, DBIT data bits, optional parity bit, stop period.
- Sits between the bus-side TX FIFO/register interface and the pad.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx.sv | 88 ++++++++
 tb/tb_uart_tx.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, oversampling factor and parity helper
package uart_pkg;
    localparam int OVERSAMPLE = 16;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
    function automatic logic parity_bit(input logic [7:0] d, input int dbit, input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < 8; i++)
            if (i < dbit) p ^= d[i];
        return p;
    endfunction
endpackage

// File: rtl/uart_tx.sv
// uart_tx: 16x-oversampled UART transmitter, LSB-first with optional parity and registered tx
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx_busy,
    output logic       tx_done_tick,
    output logic       tx
);
    state_t state, state_next;
    logic [4:0] s, s_next;
    logic [2:0] n, n_next;
    logic [DBIT-1:0] b, b_next;
    logic par, par_next, tx_next, bit_end;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            s     <= '0;
            n     <= '0;
            b     <= '0;
            par   <= 1'b0;
            tx    <= 1'b1;
        end else begin
            state <= state_next;
            s     <= s_next;
            n     <= n_next;
            b     <= b_next;
            par   <= par_next;
            tx    <= tx_next;
        end
    end
    assign tx_busy = state != IDLE;
    always_comb begin
        state_next   = state;
        s_next       = s;
        n_next       = n;
        b_next       = b;
        par_next     = par;
        tx_done_tick = 1'b0;
        bit_end      = s_tick && s == 5'(OVERSAMPLE - 1);
        unique case (state)
            IDLE:
                if (tx_start) begin
                    state_next = START;
                    s_next     = '0;
                    b_next     = din[DBIT-1:0];
                    par_next   = parity_bit(din, DBIT, PARITY_ODD);
                end
            START:
                if (bit_end) begin
                    state_next = DATA;
                    s_next     = '0;
                    n_next     = '0;
                end else if (s_tick) s_next = s + 5'd1;
            DATA:
                if (bit_end) begin
                    s_next = '0;
                    b_next = b >> 1;
                    if (n == 3'(DBIT - 1)) state_next = PARITY_EN ? PARITY : STOP;
                    else n_next = n + 3'd1;
                end else if (s_tick) s_next = s + 5'd1;
            PARITY:
                if (bit_end) begin
                    state_next = STOP;
                    s_next     = '0;
                end else if (s_tick) s_next = s + 5'd1;
            STOP:
                if (s_tick && s == 5'(SB_TICK - 1)) begin
                    state_next   = IDLE;
                    tx_done_tick = !reset;
                end else if (s_tick) s_next = s + 5'd1;
            default: state_next = IDLE;
        endcase
        // tx is registered from the next-state view so it changes on the same edge as the state
        tx_next = (state_next == START) ? 1'b0 :
                  (state_next == DATA)  ? b_next[0] :
                  (state_next == PARITY) ? par_next : 1'b1;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven frames, corner sequences and random traffic against a tick-count frame model
module tb_uart_tx;
    logic clk = 1'b0, reset = 1'b1, s_tick = 1'b0, tx_start = 1'b0;
    logic [7:0] din = 8'h00;
    logic [3:0] txv, busyv, donev;
    int errors = 0, checks = 0;
    int dbit[4] = '{8, 8, 8, 7};
    int sbt[4]  = '{16, 16, 16, 32};
    int pen[4]  = '{0, 1, 1, 0};
    int podd[4] = '{0, 0, 1, 0};
    int lens[4] = '{160, 176, 176, 160};
    bit act[4];
    int cnt[4];
    logic [7:0] dat[4];
    bit armed = 1'b0;
    logic [10:0] smp[4];
    int done_at[4], ndone[4];
    typedef struct { logic [7:0] din; logic pe; logic po; } vec_t;
    vec_t tbl[7];

    always #5 clk = ~clk;

    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u0 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
        .tx_busy(busyv[0]), .tx_done_tick(donev[0]), .tx(txv[0]));
    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u1 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
        .tx_busy(busyv[1]), .tx_done_tick(donev[1]), .tx(txv[1]));
    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u2 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
        .tx_busy(busyv[2]), .tx_done_tick(donev[2]), .tx(txv[2]));
    uart_tx #(.DBIT(7), .SB_TICK(32), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u3 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
        .tx_busy(busyv[3]), .tx_done_tick(donev[3]), .tx(txv[3]));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int flen(int i);
        return 16 * (1 + dbit[i] + pen[i]) + sbt[i];
    endfunction

    // Expected line level from the number of ticks seen since acceptance
    function automatic logic exp_tx(int i);
        int idx;
        logic [7:0] m;
        idx = cnt[i] / 16;
        m = dat[i] & 8'((1 << dbit[i]) - 1);
        if (!act[i] || idx > dbit[i] + pen[i]) return 1'b1;
        if (idx == 0) return 1'b0;
        if (idx <= dbit[i]) return m[idx-1];
        return 1'(($countones(m) + podd[i]) % 2);
    endfunction

    task automatic step(input logic t, input logic st, input logic [7:0] d, input logic r);
        @(negedge clk);
        s_tick = t;
        tx_start = st;
        din = d;
        reset = r;
        #1;
        if (armed)
            for (int i = 0; i < 4; i++)
                chk($sformatf("model dut%0d {tx,busy,done}", i), {29'd0, txv[i], busyv[i], donev[i]},
                    {29'd0, exp_tx(i), act[i], act[i] && t && !r && cnt[i] == flen(i) - 1});
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                act[i] = 1'b0;
                cnt[i] = 0;
            end else if (act[i]) begin
                if (t) cnt[i]++;
                if (cnt[i] == flen(i)) act[i] = 1'b0;
            end else if (st) begin
                act[i] = 1'b1;
                cnt[i] = 0;
                dat[i] = d;
            end
        end
        if (r) armed = 1'b1;
    endtask

    task automatic run_frame(input logic [7:0] d, input bit poke);
        int tk;
        logic t, p;
        tk = 0;
        for (int i = 0; i < 4; i++) begin
            smp[i] = '0;
            done_at[i] = -1;
            ndone[i] = 0;
        end
        step(1'b0, 1'b1, d, 1'b0);
        for (int c = 0; c < 800; c++) begin
            t = (c % 4 == 3);
            p = poke && c == 200;
            step(t, p, p ? 8'h3C : ~d, 1'b0);
            for (int i = 0; i < 4; i++) begin
                if (t && tk % 16 == 8 && tk / 16 <= 10) smp[i][tk/16] = txv[i];
                if (donev[i]) begin
                    ndone[i]++;
                    done_at[i] = tk + 1;
                end
            end
            if (t) tk++;
        end
    endtask

    task automatic check_frame(input logic [7:0] d, input logic pe, input logic po);
        chk("dut0 frame bits", {21'd0, smp[0][9:0]}, {22'd0, 1'b1, d, 1'b0});
        chk("dut1 even parity frame bits", {21'd0, smp[1]}, {21'd0, 1'b1, pe, d, 1'b0});
        chk("dut2 odd parity frame bits", {21'd0, smp[2]}, {21'd0, 1'b1, po, d, 1'b0});
        chk("dut3 7-bit frame bits", {21'd0, smp[3][9:0]}, {22'd0, 2'b11, d[6:0], 1'b0});
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("dut%0d frame ticks", i), done_at[i], lens[i]);
            chk($sformatf("dut%0d done pulses", i), ndone[i], 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen, nd;
        logic t;
        tbl[0] = '{8'hA5, 1'b0, 1'b1};
        tbl[1] = '{8'h07, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 1'b0, 1'b1};
        tbl[3] = '{8'h00, 1'b0, 1'b1};
        tbl[4] = '{8'h3C, 1'b0, 1'b1};
        tbl[5] = '{8'h01, 1'b1, 1'b0};
        tbl[6] = '{8'h80, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            act[i] = 1'b0;
            cnt[i] = 0;
            dat[i] = 8'h00;
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("reset tx", {28'd0, txv}, 32'hF);
        chk("reset busy", {28'd0, busyv}, 32'h0);
        chk("reset done", {28'd0, donev}, 32'h0);
        for (int k = 0; k < 7; k++) begin
            run_frame(tbl[k].din, 1'b0);
            check_frame(tbl[k].din, tbl[k].pe, tbl[k].po);
        end
        run_frame(8'h55, 1'b1);
        check_frame(8'h55, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'h55, 1'b0);
        for (int c = 0; c < 4 * 72; c++) step(c % 4 == 3, 1'b0, 8'h55, 1'b0);
        step(1'b0, 1'b0, 8'h55, 1'b1);
        step(1'b0, 1'b0, 8'h55, 1'b0);
        chk("abort tx", {28'd0, txv}, 32'hF);
        chk("abort busy", {28'd0, busyv}, 32'h0);
        nd = 0;
        for (int c = 0; c < 200; c++) begin
            step(c % 4 == 3, 1'b0, 8'h55, 1'b0);
            nd += int'(donev != 4'h0);
        end
        chk("abort no done", nd, 0);
        run_frame(8'hFF, 1'b0);
        check_frame(8'hFF, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'h01, 1'b0);
        seen = 0;
        for (int c = 0; c < 1000 && seen == 0; c++) begin
            step(c % 4 == 3, 1'b1, 8'h01, 1'b0);
            seen = int'(donev[0]);
        end
        chk("b2b first done", seen, 1);
        step(1'b0, 1'b1, 8'h80, 1'b0);
        chk("b2b idle gap tx/busy", {30'd0, txv[0], busyv[0]}, 32'h2);
        step(1'b0, 1'b0, 8'h80, 1'b0);
        chk("b2b second start tx/busy", {30'd0, txv[0], busyv[0]}, 32'h1);
        for (int c = 0; c < 800; c++) step(c % 4 == 3, 1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 15000; c++) begin
            t = ((c / 1000) % 5 == 4) ? 1'b0 : ($urandom_range(0, 2) == 0);
            step(t, $urandom_range(0, 40) == 0, 8'($urandom), $urandom_range(0, 2999) == 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
